// File: rtl/npc_pkg.sv
//------------------------------------------------------------------------------
// npc_pkg : shared RV32I opcode constants, instruction format codes, decoder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package npc_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_UNK = 3'd7
    } fmt_e;

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;

    function automatic fmt_e decode_fmt(input logic [6:0] opc);
        case (opc)
            c_OPC_OP:                                           return FMT_R;
            c_OPC_OP_IMM, c_OPC_LOAD, c_OPC_JALR, c_OPC_SYSTEM: return FMT_I;
            c_OPC_STORE:                                        return FMT_S;
            c_OPC_BRANCH:                                       return FMT_B;
            c_OPC_LUI, c_OPC_AUIPC:                             return FMT_U;
            c_OPC_JAL:                                          return FMT_J;
            default:                                            return FMT_UNK;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/idu_imm_gen.sv
//------------------------------------------------------------------------------
// idu_imm_gen : combinational RV32I immediate extraction for a decoded format.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module idu_imm_gen
    import npc_pkg::*;
(
    input  logic [31:0] inst_i,
    input  fmt_e        fmt_i,
    output logic [31:0] imm_o
);

    // Opcode bits never contribute to the immediate.
    logic w_unused_opc;
    assign w_unused_opc = ^inst_i[6:0];

    always_comb begin
        imm_o = 32'd0;
        case (fmt_i)
            FMT_I: imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
            FMT_S: imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            FMT_B: imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                            inst_i[30:25], inst_i[11:8], 1'b0};
            FMT_U: imm_o = {inst_i[31:12], 12'd0};
            FMT_J: imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                            inst_i[20], inst_i[30:21], 1'b0};
            default: imm_o = 32'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/idu.sv
//------------------------------------------------------------------------------
// idu : fetch queue (circular FIFO) with RV32I decode of the head entry.
//       Optional RV32E/illegal check enabled by macro IDU_ILLEGAL_CHK_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module idu
    import npc_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic [31:0] out_imm,
    output logic [2:0]  out_fmt,
    output logic        out_illegal
);

    localparam int unsigned c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [31:0]        pc_mem   [DEPTH];
    logic [31:0]        inst_mem [DEPTH];
    logic [c_PTR_W-1:0] wptr_q, wptr_d;
    logic [c_PTR_W-1:0] rptr_q, rptr_d;
    logic [c_CNT_W-1:0] cnt_q,  cnt_d;
    logic               w_push, w_pop;
    fmt_e               w_fmt;

    assign in_ready  = (cnt_q < c_FULL);
    assign out_valid = (cnt_q != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Flush wins over any coincident push or pop.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (w_push) wptr_d = wptr_q + 1'b1;
            if (w_pop)  rptr_d = rptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            pc_mem[wptr_q]   <= in_pc;
            inst_mem[wptr_q] <= in_inst;
        end
    end

    assign out_pc   = pc_mem[rptr_q];
    assign out_inst = inst_mem[rptr_q];
    assign out_rs1  = out_inst[19:15];
    assign out_rs2  = out_inst[24:20];
    assign out_rd   = out_inst[11:7];
    assign w_fmt    = decode_fmt(out_inst[6:0]);
    assign out_fmt  = w_fmt;

    idu_imm_gen u_imm_gen (
        .inst_i (out_inst),
        .fmt_i  (w_fmt),
        .imm_o  (out_imm)
    );

`ifdef IDU_ILLEGAL_CHK_EN
    logic w_use_rs1, w_use_rs2, w_use_rd;

    always_comb begin
        w_use_rs1   = (w_fmt == FMT_R) || (w_fmt == FMT_I) ||
                      (w_fmt == FMT_S) || (w_fmt == FMT_B);
        w_use_rs2   = (w_fmt == FMT_R) || (w_fmt == FMT_S) || (w_fmt == FMT_B);
        w_use_rd    = (w_fmt == FMT_R) || (w_fmt == FMT_I) ||
                      (w_fmt == FMT_U) || (w_fmt == FMT_J);
        // RV32E only has x0..x15, so bit 4 of any used index is illegal.
        out_illegal = (w_fmt == FMT_UNK) || (out_inst[1:0] != 2'b11) ||
                      (w_use_rs1 && out_rs1[4]) ||
                      (w_use_rs2 && out_rs2[4]) ||
                      (w_use_rd  && out_rd[4]);
    end
`else
    assign out_illegal = 1'b0;
`endif

endmodule

`default_nettype wire
